// File: rtl/fixed_matmul_accum.sv
// Tiled fixed-point matrix multiply-accumulate: each beat adds an A(ROWS x K_PAR) * B(K_PAR x COLS)
// slice into full-precision accumulators; the last beat of a tile casts the sum into a held output register.
module fixed_matmul_accum #(
  parameter int IN1_WIDTH      = 16,
  parameter int IN1_FRAC_WIDTH = 8,
  parameter int IN2_WIDTH      = 16,
  parameter int IN2_FRAC_WIDTH = 8,
  parameter int OUT_WIDTH      = 16,
  parameter int OUT_FRAC_WIDTH = 8,
  parameter int ROWS           = 2,
  parameter int K_PAR          = 4,
  parameter int COLS           = 2,
  parameter int MAX_DEPTH      = 8,
  parameter int ROUND_MODE     = 1,
  parameter int SATURATE       = 1,
  localparam int DEPTH_W       = $clog2(MAX_DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DEPTH_W-1:0]                 cfg_depth,
  input  logic [ROWS*K_PAR*IN1_WIDTH-1:0]    data_in1,
  input  logic                               data_in1_valid,
  output logic                               data_in1_ready,
  input  logic [K_PAR*COLS*IN2_WIDTH-1:0]    data_in2,
  input  logic                               data_in2_valid,
  output logic                               data_in2_ready,
  output logic [ROWS*COLS*OUT_WIDTH-1:0]     data_out,
  output logic                               data_out_valid,
  input  logic                               data_out_ready
);

  // state | meaning
  // IDLE  | no beats taken in the current tile; next beat loads the accumulators
  // ACC   | 1..depth_q-1 beats taken; next beat adds into the accumulators

  localparam int ACC_WIDTH = IN1_WIDTH + IN2_WIDTH + $clog2(K_PAR * MAX_DEPTH);
  localparam int PROD_W    = IN1_WIDTH + IN2_WIDTH;
  localparam int SHIFT     = IN1_FRAC_WIDTH + IN2_FRAC_WIDTH - OUT_FRAC_WIDTH;
  localparam int RND_SH    = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int N_OUT     = ROWS * COLS;

  localparam logic [ACC_WIDTH:0] RND = (ROUND_MODE == 1 && SHIFT > 0) ?
                                       ({{ACC_WIDTH{1'b0}}, 1'b1} << RND_SH) : '0;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic {IDLE, ACC} state_t;

  state_t                      state;
  logic [DEPTH_W-1:0]          cnt;
  logic [DEPTH_W-1:0]          depth_q;
  logic [DEPTH_W-1:0]          depth_eff;
  logic signed [ACC_WIDTH-1:0] acc      [N_OUT];
  logic signed [ACC_WIDTH-1:0] beat_sum [N_OUT];
  logic signed [ACC_WIDTH-1:0] acc_next [N_OUT];
  logic [N_OUT*OUT_WIDTH-1:0]  result;
  logic                        first_beat;
  logic                        last_beat;
  logic                        in_ready;
  logic                        accept;

  function automatic logic signed [PROD_W-1:0] mul(input logic signed [IN1_WIDTH-1:0] a,
                                                   input logic signed [IN2_WIDTH-1:0] b);
    return PROD_W'(a) * PROD_W'(b);
  endfunction

  // Round (optional), arithmetic shift, then clamp or wrap into the output format.
  function automatic logic [OUT_WIDTH-1:0] cast_out(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [ACC_WIDTH:0] ext;
    ext = {v[ACC_WIDTH-1], v} + RND;
    ext = ext >>> SHIFT;
    if (SATURATE != 0 && ext > SAT_MAX) return {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    if (SATURATE != 0 && ext < SAT_MIN) return {1'b1, {(OUT_WIDTH - 1){1'b0}}};
    return ext[OUT_WIDTH-1:0];
  endfunction

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        beat_sum[r*COLS+c] = '0;
        for (int k = 0; k < K_PAR; k++) begin
          beat_sum[r*COLS+c] = beat_sum[r*COLS+c] +
            ACC_WIDTH'(mul(data_in1[(r*K_PAR+k)*IN1_WIDTH +: IN1_WIDTH],
                           data_in2[(k*COLS+c)*IN2_WIDTH +: IN2_WIDTH]));
        end
      end
    end
  end

  always_comb begin
    result = '0;
    for (int i = 0; i < N_OUT; i++) begin
      acc_next[i] = first_beat ? beat_sum[i] : acc[i] + beat_sum[i];
      result[i*OUT_WIDTH +: OUT_WIDTH] = cast_out(acc_next[i]);
    end
  end

  always_comb begin
    depth_eff = cfg_depth;
    if (cfg_depth == '0)
      depth_eff = DEPTH_W'(1);
    else if (cfg_depth > DEPTH_W'(MAX_DEPTH))
      depth_eff = DEPTH_W'(MAX_DEPTH);
  end

  assign first_beat = (state == IDLE);
  assign last_beat  = first_beat ? (depth_eff == DEPTH_W'(1)) : (cnt + DEPTH_W'(1) == depth_q);
  // Only a result-producing beat has to wait for the output register to drain.
  assign in_ready       = !(last_beat && data_out_valid && !data_out_ready);
  assign data_in1_ready = in_ready & data_in2_valid;
  assign data_in2_ready = in_ready & data_in1_valid;
  assign accept         = data_in1_valid & data_in2_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      depth_q        <= DEPTH_W'(1);
      data_out       <= '0;
      data_out_valid <= 1'b0;
      for (int i = 0; i < N_OUT; i++) acc[i] <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < N_OUT; i++) acc[i] <= acc_next[i];
        if (first_beat) depth_q <= depth_eff;
        if (last_beat) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          state <= ACC;
          cnt   <= cnt + DEPTH_W'(1);
        end
      end
      if (accept && last_beat) begin
        data_out       <= result;
        data_out_valid <= 1'b1;
      end else if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fixed_matmul_accum.sv
// Scoreboard bench: two instances (round+saturate, truncate+wrap) share stimulus; a plain-arithmetic
// model keeps full-precision tile sums in a queue that an independent monitor pops on each output handshake.
module tb_fixed_matmul_accum;
  localparam int R = 2, K = 2, C = 2, W = 16, MD = 8, DW = 4, S = 8, N = R * C;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [DW-1:0]  cfg_depth;
  logic [R*K*W-1:0] a_bus;
  logic [K*C*W-1:0] b_bus;
  logic           v1, v2;
  logic           r1_0, r2_0, r1_1, r2_1;
  logic [N*W-1:0] dout0, dout1;
  logic           ov0, ov1;
  logic           out_ready;

  always #5 clk = ~clk;

  fixed_matmul_accum #(.ROWS(R), .K_PAR(K), .COLS(C), .MAX_DEPTH(MD), .ROUND_MODE(1), .SATURATE(1)) dut0 (
    .clk(clk), .rst(rst), .cfg_depth(cfg_depth),
    .data_in1(a_bus), .data_in1_valid(v1), .data_in1_ready(r1_0),
    .data_in2(b_bus), .data_in2_valid(v2), .data_in2_ready(r2_0),
    .data_out(dout0), .data_out_valid(ov0), .data_out_ready(out_ready));

  fixed_matmul_accum #(.ROWS(R), .K_PAR(K), .COLS(C), .MAX_DEPTH(MD), .ROUND_MODE(0), .SATURATE(0)) dut1 (
    .clk(clk), .rst(rst), .cfg_depth(cfg_depth),
    .data_in1(a_bus), .data_in1_valid(v1), .data_in1_ready(r1_1),
    .data_in2(b_bus), .data_in2_valid(v2), .data_in2_ready(r2_1),
    .data_out(dout1), .data_out_valid(ov1), .data_out_ready(out_ready));

  int     checks = 0;
  int     errors = 0;
  longint sums[N];
  int     tile_beats = 0;
  int     tile_depth = 1;
  longint exp_q[$];
  int     ready_mode = 2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] cast_m(input longint v, input bit rnd, input bit sat);
    longint s;
    s = v;
    if (rnd) s = s + (longint'(1) <<< (S - 1));
    s = s >>> S;
    if (sat) begin
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
    end
    return s[15:0];
  endfunction

  function automatic void model_beat(input logic [63:0] a, input logic [63:0] b, input logic [DW-1:0] cfg);
    if (tile_beats == 0) begin
      tile_depth = (cfg == 0) ? 1 : (int'(cfg) > MD) ? MD : int'(cfg);
      for (int i = 0; i < N; i++) sums[i] = 0;
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        for (int k = 0; k < K; k++)
          sums[r*C+c] += longint'($signed(a[(r*K+k)*W +: W])) * longint'($signed(b[(k*C+c)*W +: W]));
    tile_beats++;
    if (tile_beats == tile_depth) begin
      for (int i = 0; i < N; i++) exp_q.push_back(sums[i]);
      tile_beats = 0;
    end
  endfunction

  function automatic logic [63:0] rand_slice();
    logic [63:0] v;
    bit big;
    big = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 4; i++)
      v[i*16 +: 16] = big ? 16'($urandom) : 16'(int'($urandom_range(0, 1023)) - 512);
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the beat was taken.
  task automatic issue_beat(input logic [63:0] a, input logic [63:0] b, input logic [DW-1:0] cfg,
                            output int waited);
    int gap;
    bit ok;
    gap = $urandom_range(0, 2);
    a_bus = a; b_bus = b; cfg_depth = cfg;
    if (gap > 0) begin
      if ($urandom_range(0, 1) == 1) v1 = 1'b1; else v2 = 1'b1;
      repeat (gap) begin @(posedge clk); #1; end
    end
    v1 = 1'b1; v2 = 1'b1;
    waited = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      if (r1_0 && r2_0) begin ok = 1'b1; break; end
      waited++;
      if (waited > 100) begin
        check("beat_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    if (ok) model_beat(a, b, cfg);
    @(posedge clk); #1;
    v1 = 1'b0; v2 = 1'b0;
    a_bus = {$urandom, $urandom}; b_bus = {$urandom, $urandom};
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 9) < 7);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops expected values on each output handshake; checks hold under back-pressure.
  initial begin
    bit hold;
    logic [N*W-1:0] held;
    longint v;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin hold = 1'b0; continue; end
      if (hold) begin
        check("hold_valid", 64'(ov0), 64'd1);
        check("hold_data", dout0, held);
      end
      if (ov0 && out_ready) begin
        check("valid_trunc_inst", 64'(ov1), 64'd1);
        if (exp_q.size() < N) begin
          check("unexpected_output", 64'(exp_q.size()), 64'(N));
        end else begin
          for (int e = 0; e < N; e++) begin
            v = exp_q.pop_front();
            check($sformatf("out_rs_e%0d", e), 64'(dout0[e*W +: W]), 64'(cast_m(v, 1, 1)));
            check($sformatf("out_tw_e%0d", e), 64'(dout1[e*W +: W]), 64'(cast_m(v, 0, 0)));
          end
        end
      end
      hold = ov0 && !out_ready;
      held = dout0;
    end
  end

  initial begin
    int w;
    int beats;
    v1 = 1'b0; v2 = 1'b0; a_bus = '0; b_bus = '0; cfg_depth = 4'd1;
    #1;
    check("rst_valid", 64'(ov0), 64'd0);
    check("rst_data", dout0, 64'd0);
    v2 = 1'b1; #1;
    check("rst_in_ready", 64'(r1_0), 64'd1);
    v2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // identity B passes A through
    issue_beat(64'h0400_0300_0200_0100, 64'h0100_0000_0000_0100, 4'd1, w);
    check("ident_valid", 64'(ov0), 64'd1);
    check("ident_data", dout0, 64'h0400_0300_0200_0100);

    // three-beat tile; depth only sampled on the first beat
    issue_beat(64'h0080_0080_0080_0080, 64'h0100_0100_0100_0100, 4'd3, w);
    check("depth3_b1_valid", 64'(ov0), 64'd0);
    issue_beat(64'h0080_0080_0080_0080, 64'h0100_0100_0100_0100, 4'd1, w);
    check("depth3_b2_valid", 64'(ov0), 64'd0);
    issue_beat(64'h0080_0080_0080_0080, 64'h0100_0100_0100_0100, 4'd1, w);
    check("depth3_valid", 64'(ov0), 64'd1);
    check("depth3_data", dout0, 64'h0300_0300_0300_0300);

    // +/-200.0: saturate vs wrap
    issue_beat(64'h6400_6400_6400_6400, 64'h0100_0100_0100_0100, 4'd1, w);
    check("sat_pos", dout0, 64'h7FFF_7FFF_7FFF_7FFF);
    check("wrap_pos", dout1, 64'hC800_C800_C800_C800);
    issue_beat(64'h9C00_9C00_9C00_9C00, 64'h0100_0100_0100_0100, 4'd1, w);
    check("sat_neg", dout0, 64'h8000_8000_8000_8000);
    check("wrap_neg", dout1, 64'h3800_3800_3800_3800);

    // +/-2^-9: round half up vs truncate
    issue_beat(64'h0001_0001_0001_0001, 64'h0000_0000_0080_0080, 4'd1, w);
    check("round_pos", dout0, 64'h0001_0001_0001_0001);
    check("trunc_pos", dout1, 64'h0000_0000_0000_0000);
    issue_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0080_0080, 4'd1, w);
    check("round_neg", dout0, 64'h0000_0000_0000_0000);
    check("trunc_neg", dout1, 64'hFFFF_FFFF_FFFF_FFFF);

    // back-pressure: non-last beats proceed, last beat stalls, then zero-bubble replace
    repeat (2) begin @(posedge clk); #1; end
    ready_mode = 1;
    issue_beat(rand_slice(), rand_slice(), 4'd2, w);
    issue_beat(rand_slice(), rand_slice(), 4'd2, w);
    issue_beat(rand_slice(), rand_slice(), 4'd2, w);
    check("bp_nonlast_wait", 64'(w), 64'd0);
    fork
      issue_beat(rand_slice(), rand_slice(), 4'd2, w);
      begin repeat (10) @(posedge clk); ready_mode = 2; end
    join
    check("bp_stalled", 64'(w >= 8), 64'd1);
    check("bp_valid_kept", 64'(ov0), 64'd1);

    // reset mid-tile with a pending output
    repeat (3) begin @(posedge clk); #1; end
    ready_mode = 1;
    issue_beat(rand_slice(), rand_slice(), 4'd1, w);
    issue_beat(rand_slice(), rand_slice(), 4'd3, w);
    check("pre_rst_valid", 64'(ov0), 64'd1);
    rst = 1'b0;
    exp_q.delete();
    tile_beats = 0;
    #1;
    check("rst_async_valid", 64'(ov0), 64'd0);
    check("rst_async_data", dout0, 64'd0);
    v2 = 1'b1; #1;
    check("rst_ready_mid", 64'(r1_0), 64'd1);
    v2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    ready_mode = 2;
    for (int i = 0; i < 3; i++) issue_beat(rand_slice(), rand_slice(), 4'd3, w);
    check("post_rst_valid", 64'(ov0), 64'd1);

    // randomized traffic with random depth and output back-pressure
    ready_mode = 0;
    beats = 0;
    while (beats < 150 || tile_beats != 0) begin
      issue_beat(rand_slice(), rand_slice(), 4'($urandom_range(0, 15)), w);
      beats++;
    end

    ready_mode = 2;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
